// File: rtl/pixel_block_packer_if.sv
// Handshake bundle between a pixel byte source, the block packer and the DES block sink.
// The packer side uses the slave modport; the source/sink side (bench or neighbours) uses master.
// CNT_W must match the packer's CNT_W so blk_idx widths line up.
interface pixel_block_packer_if #(
  parameter int CNT_W = 16
);
  // Pixel byte stream into the packer.
  logic [7:0]       pix_data;
  logic             pix_valid;
  logic             pix_last;
  logic             pix_ready;
  // 64-bit block stream out of the packer.
  logic [63:0]      blk_data;
  logic             blk_valid;
  logic             blk_ready;
  logic             blk_last;
  logic [2:0]       blk_pad;
  logic [CNT_W-1:0] blk_idx;
  // Partial-block discard pulse.
  logic             err_drop;

  // Environment view: drives pixels in and ready for blocks, observes the rest.
  modport master (
    output pix_data, pix_valid, pix_last, blk_ready,
    input  pix_ready, blk_data, blk_valid, blk_last, blk_pad, blk_idx, err_drop
  );

  // Packer view.
  modport slave (
    input  pix_data, pix_valid, pix_last, blk_ready,
    output pix_ready, blk_data, blk_valid, blk_last, blk_pad, blk_idx, err_drop
  );
endinterface

// File: rtl/pixel_block_packer.sv
// Packs eight 8-bit pixels (first byte -> bits [63:56], DES bit 1) into a 64-bit block with frame tracking.
// Latency: block visible one cycle after its completing byte is accepted when the output slot is free.
// Backpressure: two slots (assembly + output); pix_ready = !asm_full, never depends on pix_valid or blk_ready.
// Build option PIXEL_PACKER_PAD_EN: short final blocks are zero-padded and emitted instead of dropped.
module pixel_block_packer #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pixel_block_packer_if.slave   bus
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  // Assembly register state.
  logic [63:0]      asm_dat_q,  asm_dat_d;
  logic [2:0]       fcnt_q,     fcnt_d;
  logic             asm_full_q, asm_full_d;
  logic             asm_last_q, asm_last_d;
  logic [2:0]       asm_pad_q,  asm_pad_d;

  // Output slot state, registered together so all block fields stay aligned.
  slot_e            slot_q,      slot_d;
  logic [63:0]      slot_dat_q,  slot_dat_d;
  logic             slot_last_q, slot_last_d;
  logic [2:0]       slot_pad_q,  slot_pad_d;
  logic [CNT_W-1:0] idx_q,       idx_d;
  logic             err_q,       err_d;

  // Per-cycle decisions.
  logic             pix_acc;
  logic             blk_cons;
  logic             slot_free;
  logic             byte_full8;
  logic             blk_done;
  logic             blk_drop;
  logic [5:0]       byte_sh;
  logic [63:0]      merged_dat;
  logic [2:0]       pad_new;

  // Decode handshakes and build the block image including the byte being accepted.
  always_comb begin
    pix_acc    = bus.pix_valid && !asm_full_q;
    blk_cons   = (slot_q == SLOT_FULL) && bus.blk_ready;
    // The only combinational dependency on blk_ready: a slot being consumed can be reloaded this edge.
    slot_free  = (slot_q == SLOT_EMPTY) || bus.blk_ready;
    byte_full8 = (fcnt_q == 3'd7);
    // Byte k lands at bits [63-8k -: 8]; a fresh block starts from zero so short blocks pad naturally.
    byte_sh    = 6'd56 - {fcnt_q, 3'b000};
    merged_dat = ((fcnt_q == 3'd0) ? 64'd0 : asm_dat_q) | ({56'd0, bus.pix_data} << byte_sh);
`ifdef PIXEL_PACKER_PAD_EN
    blk_done   = pix_acc && (byte_full8 || bus.pix_last);
    blk_drop   = 1'b0;
    pad_new    = byte_full8 ? 3'd0 : (3'd7 - fcnt_q);
`else
    blk_done   = pix_acc && byte_full8;
    blk_drop   = pix_acc && bus.pix_last && !byte_full8;
    pad_new    = 3'd0;
`endif
  end

  // Next-state for assembly, output slot and frame index.
  always_comb begin
    asm_dat_d   = asm_dat_q;
    fcnt_d      = fcnt_q;
    asm_full_d  = asm_full_q;
    asm_last_d  = asm_last_q;
    asm_pad_d   = asm_pad_q;
    slot_d      = blk_cons ? SLOT_EMPTY : slot_q;
    slot_dat_d  = slot_dat_q;
    slot_last_d = slot_last_q;
    slot_pad_d  = slot_pad_q;
    idx_d       = idx_q;
    err_d       = blk_drop;

    if (pix_acc) begin
      asm_dat_d = merged_dat;
      fcnt_d    = (blk_done || blk_drop) ? 3'd0 : (fcnt_q + 3'd1);
    end

    // A parked block has priority for the slot; while parked no byte can be accepted,
    // so this never coincides with a new completion.
    if (asm_full_q && slot_free) begin
      slot_d      = SLOT_FULL;
      slot_dat_d  = asm_dat_q;
      slot_last_d = asm_last_q;
      slot_pad_d  = asm_pad_q;
      asm_full_d  = 1'b0;
    end else if (blk_done) begin
      if (slot_free) begin
        slot_d      = SLOT_FULL;
        slot_dat_d  = merged_dat;
        slot_last_d = bus.pix_last;
        slot_pad_d  = pad_new;
      end else begin
        asm_full_d  = 1'b1;
        asm_last_d  = bus.pix_last;
        asm_pad_d   = pad_new;
      end
    end

    // Index counts consumed blocks and restarts after the frame's last block.
    if (blk_cons) begin
      idx_d = slot_last_q ? '0 : (idx_q + CNT_W'(1));
    end
    // A discarded tail ends the frame too.
    if (blk_drop) begin
      idx_d = '0;
    end
  end

  // State registers with synchronous reset; reset discards everything silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_dat_q   <= 64'd0;
      fcnt_q      <= 3'd0;
      asm_full_q  <= 1'b0;
      asm_last_q  <= 1'b0;
      asm_pad_q   <= 3'd0;
      slot_q      <= SLOT_EMPTY;
      slot_dat_q  <= 64'd0;
      slot_last_q <= 1'b0;
      slot_pad_q  <= 3'd0;
      idx_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      asm_dat_q   <= asm_dat_d;
      fcnt_q      <= fcnt_d;
      asm_full_q  <= asm_full_d;
      asm_last_q  <= asm_last_d;
      asm_pad_q   <= asm_pad_d;
      slot_q      <= slot_d;
      slot_dat_q  <= slot_dat_d;
      slot_last_q <= slot_last_d;
      slot_pad_q  <= slot_pad_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
    end
  end

  assign bus.pix_ready = !asm_full_q;
  assign bus.blk_valid = (slot_q == SLOT_FULL);
  assign bus.blk_data  = slot_dat_q;
  assign bus.blk_last  = slot_last_q;
  assign bus.blk_pad   = slot_pad_q;
  assign bus.blk_idx   = idx_q;
  assign bus.err_drop  = err_q;

endmodule

// File: doc/pixel_block_packer.md
# pixel_block_packer

Upstream stage of the DES image-encryption datapath. Accepts an 8-bit pixel stream with a valid/ready handshake and packs eight consecutive pixels into one 64-bit plaintext block for the `enigma` core's `img[64:1]` input. Tracks frame boundaries and counts blocks per frame. A two-slot buffer (assembly register plus output register) keeps input flowing while the downstream stage holds a block.

## Interface
- `CNT_W`, 16: width of the per-frame block counter.

- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pix_data`  in  8  pixel byte.
- `pix_valid`  in  1  `pix_data`/`pix_last` are valid.
- `pix_last`  in  1  this byte is the final byte of the frame.
- `pix_ready`  out  1  packer accepts a byte this cycle.
- `blk_data`  out  64  packed block, DES bit order.
- `blk_valid`  out  1  `blk_data` holds a block.
- `blk_ready`  in  1  downstream accepts the block.
- `blk_last`  out  1  block ends the frame.
- `blk_pad`  out  3  number of zero pad bytes in the block (0–7).
- `blk_idx`  out  CNT_W  index of the current block within the frame, starting at 0.
- `err_drop`  out  1  one-cycle pulse when a partial block is discarded.

## Operation
- A byte is accepted when `pix_valid && pix_ready`. A block is consumed when `blk_valid && blk_ready`.
- Packing order: byte k (k = 0..7, in arrival order) goes to `blk_data[64-8k : 57-8k]`. The first byte occupies bits [64:57], which is DES bit 1.
- The assembly register tracks a fill count `fcnt` (0..7) and an `asm_full` flag.
- Output slot state: EMPTY or FULL. `blk_valid` is 1 exactly when the slot is FULL.
- A block completes when an accepted byte is the 8th byte, or when it carries `pix_last`.
- On completion:
  - If the slot is EMPTY or is being consumed in the same cycle, the block loads directly into the output slot.
  - Otherwise the block stays in assembly, `asm_full` is set, and `pix_ready` drops.
- While `asm_full` is set, the block moves to the output slot in the cycle the slot frees. `asm_full` clears on that transfer.
- `pix_ready = !asm_full`. There is no combinational path from `pix_valid` to `pix_ready`. The only combinational path is from `blk_ready` to the slot-load decision; `pix_ready` itself does not depend on `blk_ready`.
- `fcnt` returns to 0 on completion, so the next byte starts a new block.
- `blk_idx`:
  - Increments by 1 on each consumed block.
  - Resets to 0 after a consumed block that has `blk_last = 1`.
  - Wraps modulo 2^CNT_W.
- `blk_last`, `blk_pad` and `blk_idx` are registered together with `blk_data` and stay stable while `blk_valid && !blk_ready`.
- `blk_data` holds its value when the slot is EMPTY.

## Timing
- Reset: the following take these values in the cycle after `rst` is sampled high, regardless of any transfer in flight.
  - `blk_valid = 0`, `blk_data = 0`, `blk_last = 0`, `blk_pad = 0`, `blk_idx = 0`, `err_drop = 0`.
  - `fcnt = 0`, `asm_full = 0`, `pix_ready = 1`.
  - A partial block is discarded silently: `err_drop` stays 0.
- Latency: the 8th byte is accepted at edge N; with the slot free, `blk_valid = 1` from N+1.
- Throughput: one byte per cycle when `blk_ready` is held high. The steady state is 1 block every 8 cycles with no input stalls.
- With `blk_ready` held low: the packer accepts 16 bytes (slot + assembly), then holds `pix_ready = 0`. When the slot frees, the assembly block moves in at the next edge and `pix_ready` returns to 1 at that edge.
- Simultaneous slot consume and assembly completion load the new block with no bubble.

## Configuration
- Macro: `PIXEL_PACKER_PAD_EN`.
- Defined:
  - `pix_last` on byte k < 8 completes the block with zero bytes in positions k+1..8.
  - `blk_pad = 8 - k`, `blk_last = 1`.
  - `err_drop` is tied to 0.
- Undefined:
  - `pix_last` on byte k < 8 discards the partial bytes and emits no block.
  - `err_drop` pulses 1 for the cycle after acceptance.
  - `fcnt` and `blk_idx` reset to 0.
  - `blk_pad` is tied to 0.
- In both builds, `pix_last` on the 8th byte gives `blk_last = 1` and `blk_pad = 0`.

## Test plan
- Bytes 0x01..0x08 with `blk_ready = 1` -> `blk_valid` one cycle after the 8th byte; `blk_data = 0x0102030405060708`; `blk_idx = 0`; `blk_last = 0`.
- 24 bytes 0x00..0x17 with `pix_last` on 0x17 and `blk_ready = 1` -> three blocks: idx 0/1/2, last block `0x1011121314151617` with `blk_last = 1`; `blk_idx` reads 0 after that block is consumed.
- `blk_ready = 0`, 20 bytes offered -> `pix_ready` falls after 16 accepted bytes; raising `blk_ready` for one cycle -> block 0 consumed, block 1 moves to the slot, `pix_ready` = 1 again.
- 3 bytes 0xAA, 0xBB, 0xCC with `pix_last` on 0xCC:
  - with `PIXEL_PACKER_PAD_EN` -> `0xAABBCC0000000000`, `blk_pad = 5`, `blk_last = 1`.
  - without it -> no block, `err_drop` pulse.
- `rst` asserted after 5 bytes with the slot FULL -> next cycle `blk_valid = 0`, `pix_ready = 1`; a new block of 8 bytes then packs from byte position 0.
- `blk_ready` toggled randomly over 1000 bytes -> blocks match a byte-order model exactly and no byte is lost or duplicated.
